// File: rtl/bcd_run_ctrl.sv
// Run-length sequencer: counts qualified ticks in cascaded BCD up to a latched
// target, with start/stop/pause control and busy/done/err status.
module bcd_run_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  internal_reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [W-1:0]   count_inc;
    logic           tgt_valid;

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple carry through the digits: a digit advances only while every
    // lower digit is wrapping from 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   d;
        carry = 1'b1;
        r     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    assign count_inc = bcd_inc(count_q);
    assign tgt_valid = bcd_valid(target);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            if (!tgt_valid) begin
                err_d = 1'b1;
            end else if (target == '0) begin
                tgt_d   = '0;
                count_d = '0;
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                tgt_d   = target;
                count_d = '0;
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        count_d = count_inc;
                        if (count_inc == tgt_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                // The tick arriving with the pause release is dropped.
                S_PAUSE: begin
                    if (!pause) state_d = S_RUN;
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: doc/bcd_run_ctrl.md
Name: bcd_run_ctrl

Overview:
- Sequencing controller for a cascaded decade (mod-10) event counter.
- Accepts a BCD target, counts qualified tick pulses in BCD, and stops at the target.
- Exposes start/stop/pause control with busy/done/err status; used as the run-length and timeout sequencer in front of display and timer datapaths.
- Fully synchronous to clk except for the reset.

Parameters:
- DIGITS, 2, number of cascaded BCD digits (1..4); count and target width = 4*DIGITS.

Ports:
- clk  input  1  system clock, rising-edge.
- internal_reset  input  1  reset, asynchronous, active-high.
- start  input  1  level-sampled; latch target and begin a run.
- stop  input  1  abort run, return to IDLE.
- pause  input  1  level; freeze counting while high.
- tick  input  1  single-cycle count-enable pulse (one event per high cycle).
- target  input  4*DIGITS  BCD terminal count, digit i at bits [4i+3:4i]; sampled only when start is accepted.
- count  output  4*DIGITS  current BCD count, registered.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on entering DONE.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async assert, sync release on clk):
  - State = IDLE; count = 0; latched target = 0.
  - busy = 0; done = 0; err = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority in every state: stop > start > pause > tick.
- Target validity: every digit must be 0..9. Any nibble 0xA..0xF makes the target invalid.
- IDLE:
  - start with valid nonzero target: latch target, clear count to 0, go to RUN next cycle.
  - start with target == 0: go to DONE directly; done pulses next cycle; count = 0.
  - start with invalid target: stay IDLE, err = 1 for exactly one cycle; count and latched target unchanged.
  - tick ignored.
- RUN:
  - tick with pause low: count increments by 1 in BCD.
  - Digit 0 increments each tick. Digit i increments only when all lower digits equal 9. Any digit at 9 that increments wraps to 0.
  - If the incremented value equals the latched target: count takes that value and the state goes to DONE in the same clock edge. done is high the following cycle (registered), one cycle wide.
  - pause high: go to PAUSE; a tick in the same cycle is ignored.
  - stop: go to IDLE; count holds its value.
  - start in RUN: restart. Re-latch target (validity rules as in IDLE), clear count to 0, remain in RUN. An invalid target pulses err and leaves the run unchanged.
- PAUSE:
  - Ticks ignored; count frozen.
  - pause low: back to RUN; a tick in that same cycle is ignored.
  - stop goes to IDLE; start restarts as in RUN.
- DONE:
  - busy = 0; count holds the target; ticks ignored.
  - start: new run, with the same rules as IDLE.
  - stop: go to IDLE, count held.
- Count never exceeds the latched target. With target = all 9s, the final tick lands on all 9s and no wrap to 0 occurs.
- busy is registered from the next state and changes on the same edge as the state.
- Reset mid-run: immediate return to IDLE with count = 0. No done or err pulse is generated on reset or on reset release.

Test Plan:
- DIGITS=2: reset held 3 cycles, released → count=0x00, busy=0, done=0, err=0.
- start with target=0x12, then 12 tick pulses spaced 2 cycles apart → count steps 0x01..0x09, 0x10, 0x11, 0x12. Requirements:
  - busy high from the cycle after start until the cycle after the 12th tick.
  - done is a single pulse the cycle after the 12th tick.
  - Further ticks leave count at 0x12.
- target=0x25, run to 0x07, assert pause 5 cycles with a tick every cycle, then release → count stays 0x07 during pause and the release cycle, resumes 0x08 on the next tick, and reaches 0x25 with done.
- start with target=0x1A → err pulses 1 cycle, state stays IDLE, busy=0, count unchanged. Then start with target=0x00 → done pulses, count=0x00.
- target=0x99, 99 ticks → count passes 0x09→0x10 and 0x89→0x90 correctly, ends at 0x99, done once, no wrap to 0x00.
- Mid-run cases with target=0x50:
  - stop and tick in the same cycle at count=0x33 → IDLE, count=0x33.
  - Restart, then assert internal_reset asynchronously between clock edges at count=0x04 → count=0x00 and busy=0 immediately, with no done or err pulse.
